mii_rx_framer: RTL and testbench
================================

MII_RX_FRAMER -- requirements
Module: mii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum frame length in bytes, DA through FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum frame length in bytes, DA through FCS.
REQ-003 SHALL have port eth_rx_clk  input  1  sole clock (PHY receive clock, 25 MHz at 100 Mb/s); all logic on its rising edge.
REQ-004 SHALL have port eth_rx_aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port eth_rx_dv  input  1  MII receive data valid.
REQ-006 SHALL have port eth_rxerr  input  1  MII receive error.
REQ-007 SHALL have port eth_rxd  input  4  MII receive nibble, low nibble of each byte first.
REQ-008 SHALL have port m_data  output  8  received byte.
REQ-009 SHALL have port m_valid  output  1  one-cycle strobe; m_data is valid.
REQ-010 SHALL have port m_last  output  1  qualifies m_valid; final byte of frame.
REQ-011 SHALL have port m_err  output  1  qualifies m_valid and m_last; frame bad.
REQ-012 SHALL have port good_cnt  output  16  count of good frames, saturating.
REQ-013 SHALL have port bad_cnt  output  16  count of bad frames, saturating.

Function
REQ-014 SHALL register eth_rx_dv, eth_rxerr and eth_rxd once before all other logic; all cycle counts below are relative to these registered copies.
REQ-015 SHALL implement FSM states IDLE, PREAMBLE, DATA and DROP.
REQ-016 IDLE SHALL go to PREAMBLE when dv=1 and rxd=0x5, and to DROP when dv=1 and rxd is any other value.
REQ-017 PREAMBLE SHALL stay while rxd=0x5, go to DATA on rxd=0xD (SFD), go to DROP on any other nibble or rxerr=1, and go to IDLE on dv=0; no output is produced in any of these cases.
REQ-018 DATA SHALL assemble byte = {second nibble, first nibble} and update CRC-32 per byte (reflected polynomial 0xEDB88320, init 0xFFFFFFFF), FCS bytes included.
REQ-019 Output SHALL use a one-byte hold register: each completed byte is emitted (m_valid=1, m_last=0) in the cycle after the next byte completes.
REQ-020 On dv falling in DATA, the held byte SHALL be emitted the following cycle with m_last=1, and the FSM SHALL return to IDLE.
REQ-021 m_err SHALL be set on the last byte if any of: rxerr seen in DATA, odd nibble count, byte count < MIN_LEN, or final CRC register != 0xDEBB20E3.
REQ-022 When byte count reaches MAX_LEN+1, that byte SHALL be emitted with m_last=1 and m_err=1, and the FSM SHALL go to DROP.
REQ-023 DROP SHALL produce no output and go to IDLE when dv=0.
REQ-024 good_cnt or bad_cnt SHALL increment by 1 in the same cycle as m_last, holding at 0xFFFF.
REQ-025 A frame that ends with zero bytes in DATA (dv falling right after SFD) SHALL emit nothing and SHALL increment bad_cnt.
REQ-026 An idle gap of at least one dv=0 cycle between frames SHALL be sufficient; back-to-back frames SHALL lose no bytes.

Reset
REQ-027 Assertion of eth_rx_aresetn SHALL asynchronously force FSM=IDLE, m_data=0, m_valid=0, m_last=0, m_err=0, good_cnt=0, bad_cnt=0, and clear the CRC and hold registers.
REQ-028 Reset released mid-frame SHALL cause entry to DROP (dv=1 with rxd != 0x5) or PREAMBLE; no partial frame SHALL be emitted.

Configuration
REQ-029 With macro MII_RX_FCS_STRIP_EN defined, the hold register SHALL be 5 bytes deep, the 4 FCS bytes SHALL never be emitted, and m_last SHALL accompany the last byte before the FCS; length and CRC checks SHALL be unchanged.
REQ-030 Without MII_RX_FCS_STRIP_EN, FCS bytes SHALL be emitted as data, as described in REQ-019 to REQ-020.
REQ-031 Under MII_RX_FCS_STRIP_EN, a frame of fewer than 5 bytes SHALL emit nothing and SHALL increment bad_cnt.

Structure
REQ-032 Package eth_pkg SHALL hold the FSM state enum, the CRC polynomial, the residue and SFD constants, and the function crc32_byte.
REQ-033 Sub-module mii_crc32 SHALL hold the per-byte CRC register, with inputs init, en and byte and output crc.

Verification
REQ-034 A 64-byte frame (60 bytes of incrementing data plus a valid FCS, 7x 0x55 preamble, 0xD5 SFD) -> 64 strobes, m_last on byte 64, m_err=0, good_cnt=1 (with strip: 60 strobes, m_last on byte 60).
REQ-035 The same frame with one payload bit flipped -> m_last with m_err=1, bad_cnt=1, good_cnt unchanged.
REQ-036 A 1519-byte frame -> m_last and m_err on byte 1519, nothing further until dv=0, bad_cnt+1.
REQ-037 rxerr pulsed at byte 20 of a 64-byte frame -> all bytes emitted, m_err=1 on last; separately, 0x3 during preamble -> no output, no counter change.
REQ-038 Two good frames with a 1-cycle gap -> 128 strobes, good_cnt=2; separately, reset asserted at byte 30 then released mid-frame -> no output for that frame, next frame good.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types, constants and CRC helper for the MII receive framer.
// MII_RX_FCS_STRIP_EN selects the 5-byte hold register that withholds the FCS.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;

`ifdef MII_RX_FCS_STRIP_EN
  localparam int HOLD_DEPTH = 5;
`else
  localparam int HOLD_DEPTH = 1;
`endif

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_framer_if.sv
// MII receive inputs and framed byte stream of the receive framer.
interface mii_rx_framer_if;
  logic       eth_rx_dv;
  logic       eth_rxerr;
  logic [3:0] eth_rxd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;

  modport master (
    input  eth_rx_dv, eth_rxerr, eth_rxd,
    output m_data, m_valid, m_last, m_err
  );

  modport slave (
    output eth_rx_dv, eth_rxerr, eth_rxd,
    input  m_data, m_valid, m_last, m_err
  );
endinterface

// File: rtl/mii_crc32.sv
// Per-byte CRC-32 register (reflected 0xEDB88320); init loads all ones, en folds in one byte.
module mii_crc32
  import eth_pkg::*;
(
  input  logic        eth_rx_clk,
  input  logic        eth_rx_aresetn,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge eth_rx_clk or negedge eth_rx_aresetn) begin
    if (!eth_rx_aresetn) begin
      crc <= '0;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles bytes, checks length/FCS, counts frames.
// Define MII_RX_FCS_STRIP_EN to keep the four FCS bytes out of the output stream.
module mii_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic            eth_rx_clk,
  input  logic            eth_rx_aresetn,
  mii_rx_framer_if.master bus,
  output logic [15:0]     good_cnt,
  output logic [15:0]     bad_cnt
);
  // state    | meaning
  // IDLE     | line quiet, waiting for dv
  // PREAMBLE | 0x5 nibbles seen, waiting for SFD nibble 0xD
  // DATA     | assembling bytes, CRC running
  // DROP     | discarding nibbles until dv falls

  localparam int HCW = $clog2(HOLD_DEPTH + 1);
  localparam logic [HCW-1:0] HOLD_FULL = HCW'(HOLD_DEPTH);

  logic           dv_q, err_q;
  logic [3:0]     rxd_q;
  rx_state_t      state, state_nxt;
  logic           hi_q;
  logic [3:0]     lo_q;
  logic [15:0]    byte_cnt;
  logic           derr_q;
  logic           ovf_q;
  logic [7:0]     hold_q [HOLD_DEPTH];
  logic [HCW-1:0] hold_cnt;
  logic [31:0]    crc;
  logic           crc_init, byte_done, frame_end, overflow;
  logic           frame_bad, hold_full;
  logic [7:0]     new_byte;
  logic           out_valid, out_last, out_err;
  logic [7:0]     out_data;
  logic           good_inc, bad_inc;

  always_ff @(posedge eth_rx_clk or negedge eth_rx_aresetn) begin
    if (!eth_rx_aresetn) begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      rxd_q <= '0;
    end else begin
      dv_q  <= bus.eth_rx_dv;
      err_q <= bus.eth_rxerr;
      rxd_q <= bus.eth_rxd;
    end
  end

  mii_crc32 u_crc (
    .eth_rx_clk     (eth_rx_clk),
    .eth_rx_aresetn (eth_rx_aresetn),
    .init           (crc_init),
    .en             (byte_done),
    .data           (new_byte),
    .crc            (crc)
  );

  assign new_byte  = {rxd_q, lo_q};
  assign hold_full = (hold_cnt == HOLD_FULL);
  // hi_q still set at dv fall means a dangling half byte
  assign frame_bad = derr_q | hi_q | (byte_cnt < 16'(MIN_LEN)) | (crc != CRC_RESIDUE);

  always_ff @(posedge eth_rx_clk or negedge eth_rx_aresetn) begin
    if (!eth_rx_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    crc_init  = 1'b0;
    byte_done = 1'b0;
    frame_end = 1'b0;
    overflow  = 1'b0;
    case (state)
      IDLE: begin
        if (dv_q) state_nxt = (rxd_q == PRE_NIB) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_nxt = IDLE;
        end else if (err_q) begin
          state_nxt = DROP;
        end else if (rxd_q == SFD_NIB) begin
          state_nxt = DATA;
          crc_init  = 1'b1;
        end else if (rxd_q != PRE_NIB) begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (!dv_q) begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end else if (hi_q) begin
          byte_done = 1'b1;
          if (byte_cnt == 16'(MAX_LEN)) begin
            overflow  = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (!dv_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_err   = 1'b0;
    out_data  = hold_q[HOLD_DEPTH-1];
    good_inc  = 1'b0;
    bad_inc   = 1'b0;
    if (byte_done && hold_full) out_valid = 1'b1;
    if (frame_end) begin
      out_valid = hold_full;
      out_last  = hold_full;
      out_err   = hold_full & frame_bad;
      good_inc  = hold_full & ~frame_bad;
      bad_inc   = ~(hold_full & ~frame_bad);
    end
    // the overflowing byte sits in the hold register one cycle after it completes
    if (ovf_q) begin
      out_valid = 1'b1;
      out_last  = 1'b1;
      out_err   = 1'b1;
      bad_inc   = 1'b1;
    end
  end

  always_ff @(posedge eth_rx_clk or negedge eth_rx_aresetn) begin
    if (!eth_rx_aresetn) begin
      hi_q     <= 1'b0;
      lo_q     <= '0;
      byte_cnt <= '0;
      derr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hold_cnt <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) hold_q[i] <= '0;
    end else begin
      ovf_q <= overflow;
      if (crc_init) begin
        hi_q     <= 1'b0;
        byte_cnt <= '0;
        derr_q   <= 1'b0;
        hold_cnt <= '0;
      end else if (state == DATA && dv_q) begin
        if (err_q) derr_q <= 1'b1;
        hi_q <= ~hi_q;
        if (!hi_q) lo_q <= rxd_q;
      end
      if (byte_done) begin
        byte_cnt  <= byte_cnt + 16'd1;
        hold_q[0] <= new_byte;
        for (int i = 1; i < HOLD_DEPTH; i++) hold_q[i] <= hold_q[i-1];
        if (!hold_full) hold_cnt <= hold_cnt + HCW'(1);
      end
      if (frame_end || ovf_q) hold_cnt <= '0;
    end
  end

  always_ff @(posedge eth_rx_clk or negedge eth_rx_aresetn) begin
    if (!eth_rx_aresetn) begin
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_err   <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      bus.m_valid <= out_valid;
      bus.m_last  <= out_last;
      bus.m_err   <= out_err;
      if (out_valid) bus.m_data <= out_data;
      if (good_inc && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      if (bad_inc && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Scoreboard bench for mii_rx_framer (default build): directed and random frames vs a frame-level model.
module tb_mii_rx_framer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] good_cnt, bad_cnt;

  mii_rx_framer_if bus ();

  mii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .eth_rx_clk     (clk),
    .eth_rx_aresetn (rst_n),
    .bus            (bus),
    .good_cnt       (good_cnt),
    .bad_cnt        (bad_cnt)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] frame[$];
  int tests = 0;
  int fails = 0;
  int model_good = 0;
  int model_bad = 0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.m_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte: got data=%h last=%b err=%b, required no output",
                 bus.m_data, bus.m_last, bus.m_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.m_data !== mon_e.data || bus.m_last !== mon_e.last || bus.m_err !== mon_e.err) begin
          fails++;
          $display("FAIL stream_byte: got data=%h last=%b err=%b, required data=%h last=%b err=%b",
                   bus.m_data, bus.m_last, bus.m_err, mon_e.data, mon_e.last, mon_e.err);
        end
      end
    end
  end

  // bit-serial Ethernet FCS over the first n bytes of frame
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ frame[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return ~r;
  endfunction

  task automatic add_fcs();
    logic [31:0] f;
    f = fcs_of(frame.size());
    for (int k = 0; k < 4; k++) frame.push_back(f[8*k +: 8]);
  endtask

  task automatic build_inc(input int plen);
    frame.delete();
    for (int i = 0; i < plen; i++) frame.push_back(8'(i));
    add_fcs();
  endtask

  task automatic build_rand(input int plen);
    frame.delete();
    for (int i = 0; i < plen; i++) frame.push_back(8'($urandom));
    add_fcs();
  endtask

  // expected output of one frame from its length and the faults the bench planted
  task automatic expect_frame(input bit faulty);
    int   n;
    bit   bad;
    exp_t e;
    n   = frame.size();
    bad = faulty || (n < MIN_LEN);
    if (n == 0) begin
      model_bad++;
    end else if (n > MAX_LEN) begin
      for (int i = 0; i <= MAX_LEN; i++) begin
        e.data = frame[i];
        e.last = (i == MAX_LEN);
        e.err  = (i == MAX_LEN);
        exp_q.push_back(e);
      end
      model_bad++;
    end else begin
      for (int i = 0; i < n; i++) begin
        e.data = frame[i];
        e.last = (i == n - 1);
        e.err  = (i == n - 1) && bad;
        exp_q.push_back(e);
      end
      if (bad) model_bad++;
      else model_good++;
    end
  endtask

  task automatic nib(input logic [3:0] d, input logic e);
    @(negedge clk);
    bus.eth_rx_dv = 1'b1;
    bus.eth_rxd   = d;
    bus.eth_rxerr = e;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.eth_rx_dv = 1'b0;
      bus.eth_rxd   = 4'h0;
      bus.eth_rxerr = 1'b0;
    end
  endtask

  task automatic send_frame(input int err_at, input bit odd, input int gap);
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    foreach (frame[i]) begin
      nib(frame[i][3:0], i == err_at);
      nib(frame[i][7:4], i == err_at);
    end
    if (odd) nib(4'($urandom), 1'b0);
    idle(gap);
  endtask

  task automatic settle(input string name);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_good_cnt"}, int'(good_cnt), model_good);
    check({name, "_bad_cnt"}, int'(bad_cnt), model_bad);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit corrupt, odd;
    int err_at, plen;
    rst_n         = 1'b1;
    bus.eth_rx_dv = 1'b0;
    bus.eth_rxd   = 4'h0;
    bus.eth_rxerr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_m_valid", int'(bus.m_valid), 0);
    check("reset_m_data", int'(bus.m_data), 0);
    check("reset_good_cnt", int'(good_cnt), 0);
    check("reset_bad_cnt", int'(bad_cnt), 0);
    rst_n = 1'b1;
    idle(2);

    // good 64-byte frame
    build_inc(60);
    expect_frame(1'b0);
    send_frame(-1, 1'b0, 4);
    settle("good64");

    // single payload bit flipped
    build_inc(60);
    frame[10] = frame[10] ^ 8'h08;
    expect_frame(1'b1);
    send_frame(-1, 1'b0, 4);
    settle("bitflip");

    // oversize: last/err on byte MAX_LEN+1, nothing after
    build_inc(MAX_LEN - 1);
    expect_frame(1'b1);
    send_frame(-1, 1'b0, 4);
    settle("oversize");

    // rxerr during byte 20
    build_inc(60);
    expect_frame(1'b1);
    send_frame(19, 1'b0, 4);
    settle("rxerr_data");

    // bad nibble 0x3 inside the preamble
    build_inc(60);
    for (int i = 0; i < 4; i++) nib(4'h5, 1'b0);
    nib(4'h3, 1'b0);
    for (int i = 0; i < 10; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    foreach (frame[i]) begin
      nib(frame[i][3:0], 1'b0);
      nib(frame[i][7:4], 1'b0);
    end
    idle(4);
    settle("pre_err");

    // back-to-back good frames with a single idle cycle
    build_inc(60);
    expect_frame(1'b0);
    send_frame(-1, 1'b0, 1);
    build_inc(60);
    expect_frame(1'b0);
    send_frame(-1, 1'b0, 4);
    settle("back2back");

    // dv falls right after SFD
    frame.delete();
    expect_frame(1'b0);
    send_frame(-1, 1'b0, 4);
    settle("zero_len");

    // random frames: length, payload, corruption, rxerr and trailing nibble
    for (int f = 0; f < 25; f++) begin
      plen    = $urandom_range(0, 90);
      build_rand(plen);
      corrupt = ($urandom_range(0, 3) == 0) && (plen > 0);
      if (corrupt) frame[$urandom_range(0, plen - 1)] ^= 8'(1 << $urandom_range(0, 7));
      odd     = ($urandom_range(0, 5) == 0);
      err_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, frame.size() - 1) : -1;
      expect_frame(corrupt || odd || (err_at >= 0));
      send_frame(err_at, odd, $urandom_range(1, 3));
    end
    idle(4);
    settle("random");

    // reset asserted inside byte 30, released inside byte 41
    build_inc(60);
    expect_frame(1'b0);
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    foreach (frame[i]) begin
      nib(frame[i][3:0], 1'b0);
      if (i == 29) begin
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_good = 0;
        model_bad  = 0;
        #1;
        check("midreset_m_valid", int'(bus.m_valid), 0);
        check("midreset_good_cnt", int'(good_cnt), 0);
        check("midreset_bad_cnt", int'(bad_cnt), 0);
      end
      if (i == 40) begin
        #2 rst_n = 1'b1;
      end
      nib(frame[i][7:4], 1'b0);
    end
    idle(4);
    settle("midreset_frame");
    build_inc(60);
    expect_frame(1'b0);
    send_frame(-1, 1'b0, 4);
    settle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
